// File: rtl/cp0_exception_unit.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_exception_unit
//  Description : Coprocessor-0 and exception controller for the EXE stage.
//                Holds Status, Cause and EPC and executes mfc0/mtc0/eret.
//                Latches external interrupt requests and takes
//                reserved-instruction exceptions and interrupts. Drives the
//                flush and PC-redirect signals back to the front end.
//                Optional build macro: CP0_TIMER_EN adds Count (9) and
//                Compare (11). A Count/Compare match raises IP7.
//  Ports       : clk, reset (sync, active-high), cpu_en (global stall)
//                EXE_undefined, EXE_cp0_operation, EXE_cp0_read_address,
//                EXE_rtdata, EXE_pc_4, int_req                      -> inputs
//                cp0_rdata, cp0_flush, cp0_redirect, cp0_redirect_pc,
//                cp0_in_handler                                     -> outputs
//  Revision    : 1.0 - initial release
// ============================================================================
module cp0_exception_unit #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_0004
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_en,
    input  logic        EXE_undefined,
    input  logic [1:0]  EXE_cp0_operation,
    input  logic [4:0]  EXE_cp0_read_address,
    input  logic [31:0] EXE_rtdata,
    input  logic [31:0] EXE_pc_4,
    input  logic        int_req,
    output logic [31:0] cp0_rdata,
    output logic        cp0_flush,
    output logic        cp0_redirect,
    output logic [31:0] cp0_redirect_pc,
    output logic        cp0_in_handler
);

    localparam logic [1:0] c_op_mtc0      = 2'b10;
    localparam logic [1:0] c_op_eret      = 2'b11;
    localparam logic [4:0] c_addr_count   = 5'd9;
    localparam logic [4:0] c_addr_compare = 5'd11;
    localparam logic [4:0] c_addr_status  = 5'd12;
    localparam logic [4:0] c_addr_cause   = 5'd13;
    localparam logic [4:0] c_addr_epc     = 5'd14;
    localparam logic [4:0] c_exc_ri       = 5'd10;
    localparam logic [4:0] c_exc_int      = 5'd0;

    // Architectural state (only the implemented bits are stored)
    logic        r_ie_q,  w_ie_d;
    logic        r_exl_q, w_exl_d;
    logic        r_im2_q, w_im2_d;
    logic        r_im7_q, w_im7_d;
    logic        r_ip2_q, w_ip2_d;
    logic [4:0]  r_exc_q, w_exc_d;
    logic [31:0] r_epc_q, w_epc_d;
    logic        w_ip7;

`ifdef CP0_TIMER_EN
    logic [31:0] r_count_q,   w_count_d;
    logic [31:0] r_compare_q, w_compare_d;
    logic        r_ip7_q,     w_ip7_d;
    assign w_ip7 = r_ip7_q;
`else
    assign w_ip7 = 1'b0;
`endif

    // Event decode, in priority order. Later events are suppressed by earlier
    // ones so a squashed instruction never touches CP0 state.
    logic w_int_pending;
    logic w_ip2_cause;
    logic w_take_undef;
    logic w_take_int;
    logic w_take_eret;
    logic w_do_mtc0;

    assign w_ip2_cause   = r_ip2_q & r_im2_q;
    assign w_int_pending = w_ip2_cause | (w_ip7 & r_im7_q);
    assign w_take_undef  = cpu_en & EXE_undefined;
    assign w_take_int    = cpu_en & ~EXE_undefined & (EXE_pc_4 != 32'd0)
                         & r_ie_q & ~r_exl_q & w_int_pending;
    assign w_take_eret   = cpu_en & ~EXE_undefined & ~w_take_int
                         & (EXE_cp0_operation == c_op_eret);
    assign w_do_mtc0     = cpu_en & ~EXE_undefined & ~w_take_int
                         & (EXE_cp0_operation == c_op_mtc0);

    assign cp0_flush      = w_take_undef | w_take_int | w_take_eret;
    assign cp0_redirect   = cp0_flush;
    assign cp0_in_handler = r_exl_q;

    always_comb begin
        cp0_redirect_pc = 32'd0;
        if (w_take_undef || w_take_int) begin
            cp0_redirect_pc = HANDLER_ADDR;
        end else if (w_take_eret) begin
            cp0_redirect_pc = r_epc_q;
        end
    end

    // mfc0 read mux: reflects state before this edge's writes
    always_comb begin
        cp0_rdata = 32'd0;
        case (EXE_cp0_read_address)
            c_addr_status: cp0_rdata = {16'd0, r_im7_q, 4'd0, r_im2_q, 8'd0, r_exl_q, r_ie_q};
            c_addr_cause:  cp0_rdata = {16'd0, w_ip7, 4'd0, r_ip2_q, 3'd0, r_exc_q, 2'd0};
            c_addr_epc:    cp0_rdata = r_epc_q;
`ifdef CP0_TIMER_EN
            c_addr_count:   cp0_rdata = r_count_q;
            c_addr_compare: cp0_rdata = r_compare_q;
`endif
            default:       cp0_rdata = 32'd0;
        endcase
    end

    always_comb begin
        w_ie_d  = r_ie_q;
        w_exl_d = r_exl_q;
        w_im2_d = r_im2_q;
        w_im7_d = r_im7_q;
        w_ip2_d = r_ip2_q;
        w_exc_d = r_exc_q;
        w_epc_d = r_epc_q;
`ifdef CP0_TIMER_EN
        w_count_d   = cpu_en ? (r_count_q + 32'd1) : r_count_q;
        w_compare_d = r_compare_q;
        w_ip7_d     = r_ip7_q;
        if (cpu_en && (r_count_q == r_compare_q) && (r_compare_q != 32'd0)) begin
            w_ip7_d = 1'b1;
        end
`endif
        if (w_take_undef) begin
            w_exc_d = c_exc_ri;
            // A fault inside the handler must not lose the original return PC
            if (!r_exl_q) begin
                w_epc_d = EXE_pc_4 - 32'd4;
            end
            w_exl_d = 1'b1;
        end else if (w_take_int) begin
            w_exc_d = c_exc_int;
            w_epc_d = EXE_pc_4 - 32'd4;
            w_exl_d = 1'b1;
            if (w_ip2_cause) begin
                w_ip2_d = 1'b0;
            end
        end else if (w_take_eret) begin
            w_exl_d = 1'b0;
        end else if (w_do_mtc0) begin
            case (EXE_cp0_read_address)
                c_addr_status: begin
                    w_ie_d  = EXE_rtdata[0];
                    w_exl_d = EXE_rtdata[1];
                    w_im2_d = EXE_rtdata[10];
                    w_im7_d = EXE_rtdata[15];
                end
                c_addr_cause: w_ip2_d = EXE_rtdata[10];
                c_addr_epc:   w_epc_d = EXE_rtdata;
`ifdef CP0_TIMER_EN
                c_addr_count: w_count_d = EXE_rtdata;
                c_addr_compare: begin
                    w_compare_d = EXE_rtdata;
                    w_ip7_d     = 1'b0;
                end
`endif
                default: ;
            endcase
        end
        // A new request is latched even on stalled cycles and wins over a
        // same-cycle clear so it is never lost.
        if (int_req) begin
            w_ip2_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ie_q  <= 1'b0;
            r_exl_q <= 1'b0;
            r_im2_q <= 1'b0;
            r_im7_q <= 1'b0;
            r_ip2_q <= 1'b0;
            r_exc_q <= 5'd0;
            r_epc_q <= 32'd0;
`ifdef CP0_TIMER_EN
            r_count_q   <= 32'd0;
            r_compare_q <= 32'd0;
            r_ip7_q     <= 1'b0;
`endif
        end else begin
            r_ie_q  <= w_ie_d;
            r_exl_q <= w_exl_d;
            r_im2_q <= w_im2_d;
            r_im7_q <= w_im7_d;
            r_ip2_q <= w_ip2_d;
            r_exc_q <= w_exc_d;
            r_epc_q <= w_epc_d;
`ifdef CP0_TIMER_EN
            r_count_q   <= w_count_d;
            r_compare_q <= w_compare_d;
            r_ip7_q     <= w_ip7_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cp0_exception_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cp0_exception_unit
//  Description : Directed self-checking bench for cp0_exception_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cp0_exception_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_en;
    logic        EXE_undefined;
    logic [1:0]  EXE_cp0_operation;
    logic [4:0]  EXE_cp0_read_address;
    logic [31:0] EXE_rtdata;
    logic [31:0] EXE_pc_4;
    logic        int_req;
    logic [31:0] cp0_rdata;
    logic        cp0_flush;
    logic        cp0_redirect;
    logic [31:0] cp0_redirect_pc;
    logic        cp0_in_handler;

    int n_checks = 0;
    int n_fail   = 0;

    cp0_exception_unit #(.HANDLER_ADDR(32'h0000_0004)) dut (
        .clk                  (clk),
        .reset                (reset),
        .cpu_en               (cpu_en),
        .EXE_undefined        (EXE_undefined),
        .EXE_cp0_operation    (EXE_cp0_operation),
        .EXE_cp0_read_address (EXE_cp0_read_address),
        .EXE_rtdata           (EXE_rtdata),
        .EXE_pc_4             (EXE_pc_4),
        .int_req              (int_req),
        .cp0_rdata            (cp0_rdata),
        .cp0_flush            (cp0_flush),
        .cp0_redirect         (cp0_redirect),
        .cp0_redirect_pc      (cp0_redirect_pc),
        .cp0_in_handler       (cp0_in_handler)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_en = 1'b1; EXE_undefined = 1'b0; EXE_cp0_operation = 2'b00;
        EXE_cp0_read_address = 5'd0; EXE_rtdata = 32'd0; EXE_pc_4 = 32'd0;
        int_req = 1'b0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
        idle();
        EXE_cp0_operation = 2'b10; EXE_cp0_read_address = a;
        EXE_rtdata = d; EXE_pc_4 = pc;
        tick();
        idle();
    endtask

    task automatic set_read(input logic [4:0] a);
        EXE_cp0_operation = 2'b01; EXE_cp0_read_address = a; #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; idle();
        tick(); tick();
        reset = 1'b0;
        #1;
        n_checks++; if (cp0_flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush got %b want 0", cp0_flush); end
        n_checks++; if (cp0_redirect !== 1'b0 || cp0_redirect_pc !== 32'd0) begin n_fail++; $display("FAIL reset_redirect got %b/%h want 0/0", cp0_redirect, cp0_redirect_pc); end
        n_checks++; if (cp0_in_handler !== 1'b0) begin n_fail++; $display("FAIL reset_exl got %b want 0", cp0_in_handler); end
        for (int a = 12; a <= 14; a++) begin
            set_read(5'(a));
            n_checks++; if (cp0_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_read%0d got %h want 0", a, cp0_rdata); end
        end
        idle();
    endtask

    task automatic test_interrupt();
        mtc0(5'd12, 32'h0000_0401, 32'h100);
        // request in the same cycle as an instruction: not yet visible
        int_req = 1'b1; EXE_pc_4 = 32'h10; #1;
        n_checks++; if (cp0_flush !== 1'b0) begin n_fail++; $display("FAIL int_same_cycle flush got %b want 0", cp0_flush); end
        tick(); idle();
        set_read(5'd13);
        n_checks++; if (cp0_rdata !== 32'h0000_0400) begin n_fail++; $display("FAIL int_ip2_latched got %h want 00000400", cp0_rdata); end
        idle(); EXE_pc_4 = 32'h40; #1;
        n_checks++; if (cp0_flush !== 1'b1 || cp0_redirect !== 1'b1) begin n_fail++; $display("FAIL int_flush got %b/%b want 1/1", cp0_flush, cp0_redirect); end
        n_checks++; if (cp0_redirect_pc !== 32'h4) begin n_fail++; $display("FAIL int_redirect_pc got %h want 00000004", cp0_redirect_pc); end
        tick(); idle();
        set_read(5'd14);
        n_checks++; if (cp0_rdata !== 32'h3C) begin n_fail++; $display("FAIL int_epc got %h want 0000003c", cp0_rdata); end
        set_read(5'd12);
        n_checks++; if (cp0_rdata !== 32'h403) begin n_fail++; $display("FAIL int_status got %h want 00000403", cp0_rdata); end
        set_read(5'd13);
        n_checks++; if (cp0_rdata !== 32'h0) begin n_fail++; $display("FAIL int_cause got %h want 00000000", cp0_rdata); end
        n_checks++; if (cp0_in_handler !== 1'b1) begin n_fail++; $display("FAIL int_in_handler got %b want 1", cp0_in_handler); end
        idle();
    endtask

    task automatic test_eret_pending();
        int_req = 1'b1; EXE_pc_4 = 32'h8; #1;
        n_checks++; if (cp0_flush !== 1'b0) begin n_fail++; $display("FAIL nested_blocked flush got %b want 0", cp0_flush); end
        tick();
        EXE_cp0_operation = 2'b11; EXE_pc_4 = 32'hC; #1;
        n_checks++; if (cp0_flush !== 1'b1 || cp0_redirect_pc !== 32'h3C) begin n_fail++; $display("FAIL eret_redirect got %b/%h want 1/0000003c", cp0_flush, cp0_redirect_pc); end
        tick(); idle(); #1;
        n_checks++; if (cp0_in_handler !== 1'b0) begin n_fail++; $display("FAIL eret_exl got %b want 0", cp0_in_handler); end
        n_checks++; if (cp0_flush !== 1'b0) begin n_fail++; $display("FAIL bubble_no_int flush got %b want 0", cp0_flush); end
        tick();
        EXE_pc_4 = 32'h44; #1;
        n_checks++; if (cp0_flush !== 1'b1 || cp0_redirect_pc !== 32'h4) begin n_fail++; $display("FAIL pending_int got %b/%h want 1/00000004", cp0_flush, cp0_redirect_pc); end
        tick(); idle();
        set_read(5'd14);
        n_checks++; if (cp0_rdata !== 32'h40) begin n_fail++; $display("FAIL pending_epc got %h want 00000040", cp0_rdata); end
        idle(); EXE_cp0_operation = 2'b11; EXE_pc_4 = 32'h48; #1;
        n_checks++; if (cp0_redirect_pc !== 32'h40) begin n_fail++; $display("FAIL eret2_pc got %h want 00000040", cp0_redirect_pc); end
        tick(); idle();
    endtask

    task automatic test_undefined();
        mtc0(5'd12, 32'h0000_0400, 32'h100);
        EXE_undefined = 1'b1; EXE_pc_4 = 32'h20; #1;
        n_checks++; if (cp0_flush !== 1'b1 || cp0_redirect_pc !== 32'h4) begin n_fail++; $display("FAIL undef_redirect got %b/%h want 1/00000004", cp0_flush, cp0_redirect_pc); end
        tick(); idle();
        set_read(5'd14);
        n_checks++; if (cp0_rdata !== 32'h1C) begin n_fail++; $display("FAIL undef_epc got %h want 0000001c", cp0_rdata); end
        set_read(5'd13);
        n_checks++; if (cp0_rdata !== 32'h28) begin n_fail++; $display("FAIL undef_cause got %h want 00000028", cp0_rdata); end
        set_read(5'd12);
        n_checks++; if (cp0_rdata !== 32'h402) begin n_fail++; $display("FAIL undef_status got %h want 00000402", cp0_rdata); end
        idle(); EXE_undefined = 1'b1; EXE_pc_4 = 32'h80; #1;
        n_checks++; if (cp0_flush !== 1'b1) begin n_fail++; $display("FAIL undef_nested flush got %b want 1", cp0_flush); end
        tick(); idle();
        set_read(5'd14);
        n_checks++; if (cp0_rdata !== 32'h1C) begin n_fail++; $display("FAIL undef_nested_epc got %h want 0000001c", cp0_rdata); end
        idle(); EXE_cp0_operation = 2'b11; EXE_pc_4 = 32'h84; #1;
        n_checks++; if (cp0_redirect_pc !== 32'h1C) begin n_fail++; $display("FAIL undef_eret_pc got %h want 0000001c", cp0_redirect_pc); end
        tick(); idle();
    endtask

    task automatic test_squash();
        mtc0(5'd12, 32'h0000_0401, 32'h100);
        int_req = 1'b1; tick(); idle();
        EXE_cp0_operation = 2'b10; EXE_cp0_read_address = 5'd14;
        EXE_rtdata = 32'hDEAD_BEE0; EXE_pc_4 = 32'h60; #1;
        n_checks++; if (cp0_flush !== 1'b1) begin n_fail++; $display("FAIL squash_flush got %b want 1", cp0_flush); end
        tick(); idle();
        set_read(5'd14);
        n_checks++; if (cp0_rdata !== 32'h5C) begin n_fail++; $display("FAIL squash_epc got %h want 0000005c", cp0_rdata); end
        idle(); EXE_cp0_operation = 2'b11; EXE_pc_4 = 32'h64; tick(); idle();
        int_req = 1'b1; tick(); idle();
        cpu_en = 1'b0; EXE_cp0_operation = 2'b10; EXE_cp0_read_address = 5'd14;
        EXE_rtdata = 32'h1234; EXE_pc_4 = 32'h70; #1;
        n_checks++; if (cp0_flush !== 1'b0 || cp0_redirect !== 1'b0) begin n_fail++; $display("FAIL stall_flush got %b/%b want 0/0", cp0_flush, cp0_redirect); end
        tick(); idle();
        set_read(5'd14);
        n_checks++; if (cp0_rdata !== 32'h5C) begin n_fail++; $display("FAIL stall_epc got %h want 0000005c", cp0_rdata); end
        set_read(5'd13);
        n_checks++; if (cp0_rdata !== 32'h400) begin n_fail++; $display("FAIL stall_cause got %h want 00000400", cp0_rdata); end
        mtc0(5'd13, 32'h0, 32'h0);
        set_read(5'd13);
        n_checks++; if (cp0_rdata !== 32'h0) begin n_fail++; $display("FAIL mtc0_cause got %h want 00000000", cp0_rdata); end
        idle();
    endtask

    task automatic test_back_to_back();
        EXE_cp0_operation = 2'b10; EXE_cp0_read_address = 5'd14;
        EXE_rtdata = 32'h1000; EXE_pc_4 = 32'h100; #1;
        n_checks++; if (cp0_rdata !== 32'h5C) begin n_fail++; $display("FAIL b2b_old got %h want 0000005c", cp0_rdata); end
        tick(); idle();
        set_read(5'd14);
        n_checks++; if (cp0_rdata !== 32'h1000) begin n_fail++; $display("FAIL b2b_new got %h want 00001000", cp0_rdata); end
        mtc0(5'd5, 32'hFFFF_FFFF, 32'h104);
        set_read(5'd5);
        n_checks++; if (cp0_rdata !== 32'h0) begin n_fail++; $display("FAIL unused_reg got %h want 00000000", cp0_rdata); end
        mtc0(5'd12, 32'hFFFF_FFFF, 32'h108);
        set_read(5'd12);
        n_checks++; if (cp0_rdata !== 32'h8403) begin n_fail++; $display("FAIL status_mask got %h want 00008403", cp0_rdata); end
        mtc0(5'd12, 32'h0, 32'h10C);
        idle();
    endtask

    task automatic test_reset_mid_handler();
        EXE_undefined = 1'b1; EXE_pc_4 = 32'h30; tick(); idle(); #1;
        n_checks++; if (cp0_in_handler !== 1'b1) begin n_fail++; $display("FAIL rmh_enter got %b want 1", cp0_in_handler); end
        int_req = 1'b1; reset = 1'b1; tick(); reset = 1'b0; idle(); #1;
        n_checks++; if (cp0_in_handler !== 1'b0) begin n_fail++; $display("FAIL rmh_exl got %b want 0", cp0_in_handler); end
        set_read(5'd13);
        n_checks++; if (cp0_rdata !== 32'h0) begin n_fail++; $display("FAIL rmh_cause got %h want 00000000", cp0_rdata); end
        set_read(5'd14);
        n_checks++; if (cp0_rdata !== 32'h0) begin n_fail++; $display("FAIL rmh_epc got %h want 00000000", cp0_rdata); end
        idle();
    endtask

`ifdef CP0_TIMER_EN
    task automatic test_timer();
        bit seen;
        seen = 1'b0;
        mtc0(5'd12, 32'h0000_8001, 32'h100);
        mtc0(5'd11, 32'd5, 32'h104);
        mtc0(5'd9, 32'd0, 32'h108);
        for (int i = 0; i < 12 && !seen; i++) begin
            set_read(5'd13);
            if (cp0_rdata[15]) seen = 1'b1;
            else tick();
        end
        n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL timer_ip7 got %b want 1", seen); end
        set_read(5'd9);
        n_checks++; if (cp0_rdata !== 32'd6) begin n_fail++; $display("FAIL timer_count got %0d want 6", cp0_rdata); end
        idle(); EXE_pc_4 = 32'h200; #1;
        n_checks++; if (cp0_flush !== 1'b1) begin n_fail++; $display("FAIL timer_int got %b want 1", cp0_flush); end
        tick(); idle();
        set_read(5'd13);
        n_checks++; if (cp0_rdata !== 32'h8000) begin n_fail++; $display("FAIL timer_cause got %h want 00008000", cp0_rdata); end
        mtc0(5'd11, 32'd0, 32'h204);
        set_read(5'd13);
        n_checks++; if (cp0_rdata !== 32'h0) begin n_fail++; $display("FAIL timer_clear got %h want 00000000", cp0_rdata); end
        idle(); EXE_cp0_operation = 2'b11; EXE_pc_4 = 32'h208; tick(); idle();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_interrupt();
        test_eret_pending();
        test_undefined();
        test_squash();
        test_back_to_back();
        test_reset_mid_handler();
`ifdef CP0_TIMER_EN
        test_timer();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cp0_exception_unit.md
# cp0_exception_unit

Coprocessor-0 and exception controller sitting at the EXE stage, consuming the `EXE_undefined`, `EXE_cp0_operation`, `EXE_cp0_read_address` and `EXE_pc_4` fields produced by the ID/EXE pipeline register. It holds Status, Cause and EPC and executes `mfc0`/`mtc0`/`eret`. It latches external interrupt requests and takes reserved-instruction exceptions and interrupts. It drives the flush and PC-redirect signals back to the front end, including the ID/EXE bubble.

## Interface
- `HANDLER_ADDR`, 32'h0000_0004, exception/interrupt vector loaded into PC on entry
- `clk`  in  1  pipeline clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `cpu_en`  in  1  global stall; when 0 no state changes and `cp0_flush`/`cp0_redirect` are forced 0
- `EXE_undefined`  in  1  instruction in EXE is undefined (reserved-instruction)
- `EXE_cp0_operation`  in  2  00 none, 01 mfc0, 10 mtc0, 11 eret
- `EXE_cp0_read_address`  in  5  CP0 register number for mfc0/mtc0
- `EXE_rtdata`  in  32  mtc0 write data
- `EXE_pc_4`  in  32  PC+4 of EXE instruction; 0 marks a bubble
- `int_req`  in  1  external interrupt, one-cycle pulse or level
- `cp0_rdata`  out  32  combinational mfc0 read data
- `cp0_flush`  out  1  squash IF/ID/EXE this cycle (feeds ID_EXE_bubble and IF/ID flush)
- `cp0_redirect`  out  1  load `cp0_redirect_pc` into PC at next edge
- `cp0_redirect_pc`  out  32  HANDLER_ADDR on entry, EPC on eret
- `cp0_in_handler`  out  1  Status.EXL

## Operation
- Registers: Status (12): bit0 IE, bit1 EXL, bit10 IM2, bit15 IM7, other bits read 0. Cause (13): bit10 IP2, bit15 IP7, [6:2] ExcCode, others 0. EPC (14): 32 bits. Other addresses read 0; writes to them are ignored.
- Reads: `cp0_rdata` = selected register by `EXE_cp0_read_address`, regardless of operation.
- IP2 is set on any cycle with `int_req`=1, independent of `cpu_en`. It is cleared only when an interrupt is taken with IP2 as its cause, or by an mtc0 to Cause.
- Interrupt condition: `EXE_pc_4`≠0, IE=1, EXL=0, and (IP2&IM2 | IP7&IM7).
- Priority per `cpu_en` cycle:
  - Undefined first: ExcCode←10. EPC←`EXE_pc_4`−4 only if EXL=0. EXL←1. Assert flush and redirect to HANDLER_ADDR.
  - Interrupt second: ExcCode←0, EPC←`EXE_pc_4`−4, EXL←1, clear the taken IP2. Assert flush and redirect to HANDLER_ADDR. The EXE instruction is squashed and re-executes after eret.
  - eret third: EXL←0. Assert flush and redirect to EPC, where `cp0_redirect_pc` is the EPC value before the edge.
  - mtc0 last: writes the addressed register using masked writable bits only.
- mtc0 to Cause writes IP2 only. IP7 is cleared only via Compare (see Configuration).
- A squashed instruction never writes CP0; e.g. an mtc0 in EXE while an interrupt is taken is dropped.
- FSM is implied by EXL: NORMAL (EXL=0) → HANDLER on exception or interrupt; HANDLER → NORMAL on eret. Nested interrupts are blocked in HANDLER, while undefined is still taken.

## Timing
- Reset: Status, Cause, EPC = 0; EXL=0; IP flags cleared; all outputs 0 (`cp0_rdata` reads 0 for all addresses).
- `cp0_flush`, `cp0_redirect` and `cp0_redirect_pc` are combinational in the same cycle the causing instruction is in EXE. Register updates take effect at that cycle's rising edge.
- Zero-latency mfc0: read sees values from before this edge's writes. An mtc0 in EXE followed by mfc0 in the next cycle reads the new value.
- `int_req` arriving in the same cycle as the interrupt condition evaluates: it is not visible until the next cycle.
- eret with a pending enabled interrupt: the eret executes first. The interrupt is taken on the first non-bubble EXE instruction afterward.
- Reset mid-handler: returns to NORMAL, pending interrupts are lost.

## Configuration
- `CP0_TIMER_EN` defined: adds Count (9) and Compare (11).
  - Count increments every `cpu_en` cycle and wraps at 2^32; an mtc0 to Count overrides that cycle's increment.
  - When Count==Compare and Compare≠0, IP7←1. An mtc0 to Compare clears IP7.
  - Both registers reset to 0.
- Not defined: addresses 9 and 11 read 0, IP7 is constant 0, and IM7 is stored but has no effect.

## Test plan
- Reset, then mfc0 addresses 12/13/14 → `cp0_rdata`=0 each; flush=0.
- mtc0 Status=32'h401, `int_req` pulse, instruction in EXE with `EXE_pc_4`=32'h40 → same cycle flush=1, redirect_pc=32'h4; next cycle EPC=32'h3C, EXL=1, ExcCode=0, IP2=0.
- `EXE_undefined`=1 at `EXE_pc_4`=32'h20 with IE=0 → redirect to 32'h4, EPC=32'h1C, ExcCode=10.
- In handler, eret with EPC=32'h3C → redirect_pc=32'h3C, EXL=0 next cycle; a second `int_req` held during handler is taken on the first non-bubble instruction after eret.
- mtc0 in EXE while an interrupt is taken, and `cpu_en`=0 with pending interrupt → the mtc0 target is unchanged in both cases, and there is no flush while `cpu_en`=0.
- `CP0_TIMER_EN`: Compare=5, Status=32'h8001 → IP7 is set when Count reaches 5, the interrupt is taken, and a write to Compare clears IP7.
